reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 31 +++
 rtl/reg_file.sv | 94 +++++++++
 2 files changed

// File: rtl/reg_file_if.sv
// Register-file access bus: one write port, two read ports, PC side-channel.
interface reg_file_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 16
);
    localparam int unsigned AW = $clog2(NREG);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [WIDTH-1:0] pc_plus8;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic             pc_wr;
    logic [WIDTH-1:0] pc_wr_data;
    logic [7:0]       wr_count;

    // Pipeline side driving requests into the register file.
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, pc_plus8,
        input  rd_data1, rd_data2, pc_wr, pc_wr_data, wr_count
    );

    // Register file side.
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, pc_plus8,
        output rd_data1, rd_data2, pc_wr, pc_wr_data, wr_count
    );
endinterface

// File: rtl/reg_file.sv
// Two-read / one-write register file. The top index is the PC: reads return
// pc_plus8, writes are forwarded out as a one-cycle pc_wr pulse instead of
// being stored. General writes are bypassed to same-cycle reads.
module reg_file #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 16
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave bus
);
    localparam int unsigned   AW     = $clog2(NREG);
    localparam int unsigned   NGEN   = NREG - 1;
    localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

    logic [WIDTH-1:0] store [NGEN];
    logic [NGEN-1:0]  slice_en;
    logic             gen_wr;
    logic             pc_hit;
    logic             pc_flag;
    logic [WIDTH-1:0] pc_data;
    logic [7:0]       count;

    // One enabled register slice per general register, with its own decode term.
    for (genvar i = 0; i < NGEN; i++) begin : g_slice
        logic [WIDTH-1:0] q;

        assign slice_en[i] = bus.wr_en && (bus.wr_addr == AW'(i));

        // Slice storage: reset clears, enable loads write data.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= '0;
            end else if (slice_en[i]) begin
                q <= bus.wr_data;
            end
        end

        assign store[i] = q;
    end

    // A general write is any write that hit a slice; out-of-range hits none.
    assign gen_wr = |slice_en;
    assign pc_hit = bus.wr_en && (bus.wr_addr == PC_IDX);

    // Read mux: PC index, bypass of an in-flight general write, stored value, else 0.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [AW-1:0]    addr,
        input logic             wen,
        input logic [AW-1:0]    waddr,
        input logic [WIDTH-1:0] wdata,
        input logic [WIDTH-1:0] pc,
        input logic [WIDTH-1:0] mem [NGEN]
    );
        logic [WIDTH-1:0] val;
        val = '0;
        if (addr == PC_IDX) begin
            val = pc;
        end else if (32'(addr) < NGEN) begin
            if (wen && (waddr == addr)) begin
                val = wdata;
            end else begin
                val = mem[addr];
            end
        end
        return val;
    endfunction

    assign bus.rd_data1 = read_port(bus.rd_addr1, bus.wr_en, bus.wr_addr,
                                    bus.wr_data, bus.pc_plus8, store);
    assign bus.rd_data2 = read_port(bus.rd_addr2, bus.wr_en, bus.wr_addr,
                                    bus.wr_data, bus.pc_plus8, store);

    // PC write pulse, captured PC data, and general-write counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_flag <= 1'b0;
            pc_data <= '0;
            count   <= '0;
        end else begin
            pc_flag <= pc_hit;
            if (pc_hit) begin
                pc_data <= bus.wr_data;
            end
            if (gen_wr) begin
                count <= count + 8'd1;
            end
        end
    end

    assign bus.pc_wr      = pc_flag;
    assign bus.pc_wr_data = pc_data;
    assign bus.wr_count   = count;
endmodule
